emulib_axi_timing_arb: RTL and testbench



---
 rtl/emulib_axi_arb_pkg.sv | 38 +++
 rtl/emulib_rr_arbiter.sv | 70 +++++++
 rtl/emulib_axi_timing_arb.sv | 258 +++++++++++++++++++++++++
 tb/tb_emulib_axi_timing_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emulib_axi_arb_pkg.sv
// emulib_axi_arb_pkg
// Shared types and helpers for the AXI timing-model arbiter slice.
//   w_state_e  : W-routing FSM states (W_IDLE, W_BURST)
//   rr_pick    : round-robin search helper used by emulib_rr_arbiter
//   CNT_WIDTH  : width of the optional per-port grant counters
package emulib_axi_arb_pkg;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } w_state_e;

  // Widest request vector rr_pick can search (NUM_PORTS must not exceed this).
  localparam int RR_MAX_PORTS = 64;
  localparam int RR_IDX_BITS  = 6;

  localparam int CNT_WIDTH = 32;

  // Returns the first set request at or after ptr, wrapping modulo num,
  // or -1 when no request is set. Iterating k downwards lets the smallest
  // distance from the pointer win without a break.
  function automatic int rr_pick(input logic [RR_MAX_PORTS-1:0] req,
                                 input int ptr,
                                 input int num);
    int pick;
    int j;
    pick = -1;
    for (int k = RR_MAX_PORTS - 1; k >= 0; k--) begin
      if (k < num) begin
        j = ptr + k;
        if (j >= num) j = j - num;
        if (req[j[RR_IDX_BITS-1:0]]) pick = j;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/emulib_rr_arbiter.sv
// emulib_rr_arbiter
// Round-robin arbiter with grant hold on stall.
//   clk, rst : clock, synchronous active-high reset
//   enable   : 0 forces no grant (used to block arbitration)
//   req      : per-port request vector
//   advance  : handshake of the current grant; rotates the pointer
//   grant    : one-hot grant
//   idx      : index of the granted port
//   valid    : a grant is being presented downstream
module emulib_rr_arbiter
  import emulib_axi_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int IDX_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 valid
);

  logic [IDX_WIDTH-1:0]    ptr_q;
  logic [IDX_WIDTH-1:0]    hold_idx_q;
  logic                    hold_q;
  logic [RR_MAX_PORTS-1:0] req_ext;
  int                      pick;

  // A held grant wins over a fresh search so the downstream payload stays
  // stable while the slave stalls, even if an earlier-priority port arrives.
  always_comb begin
    grant   = '0;
    idx     = '0;
    valid   = 1'b0;
    req_ext = RR_MAX_PORTS'(req);
    pick    = rr_pick(req_ext, int'(ptr_q), NUM_PORTS);
    if (enable) begin
      if (hold_q) begin
        idx   = hold_idx_q;
        valid = req[hold_idx_q];
      end else if (pick >= 0) begin
        idx   = IDX_WIDTH'(pick);
        valid = 1'b1;
      end
      if (valid) grant[idx] = 1'b1;
    end
  end

  // Pointer moves only on a completed handshake; a presented but unaccepted
  // grant is captured so it survives into the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else if (advance) begin
      ptr_q  <= (idx == IDX_WIDTH'(NUM_PORTS - 1)) ? '0 : idx + 1'b1;
      hold_q <= 1'b0;
    end else if (valid) begin
      hold_q     <= 1'b1;
      hold_idx_q <= idx;
    end else begin
      hold_q <= 1'b0;
    end
  end

endmodule

// File: rtl/emulib_axi_timing_arb.sv
// emulib_axi_timing_arb
// Shares one AXI memory timing model between NUM_PORTS requesters.
// Only handshakes and tags are carried (valid/ready, IDs, lengths, wlast).
// The requester index is prepended to the downstream ID and used to route
// R/B responses back.
//   clk, rst      : clock, synchronous active-high reset
//   s_ar*, s_aw*  : per-port address channels (flattened, port i at slice i)
//   s_w*          : per-port W handshake and last
//   s_r*, s_b*    : per-port response handshakes and IDs
//   m_ar*, m_aw*  : single downstream address channels, id = {index, id}
//   m_w*, m_r*, m_b* : single downstream W and response channels
// Optional: define EMULIB_TIMING_ARB_STATS_EN to add ar_grant_cnt and
// aw_grant_cnt (NUM_PORTS*32 each, saturating per-port grant counters).
module emulib_axi_timing_arb
  import emulib_axi_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  localparam int IDX_WIDTH = $clog2(NUM_PORTS),
  localparam int MID_WIDTH = ID_WIDTH + IDX_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            s_arvalid,
  output logic [NUM_PORTS-1:0]            s_arready,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]   s_arid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_PORTS*8-1:0]          s_arlen,
  input  logic [NUM_PORTS*3-1:0]          s_arsize,
  input  logic [NUM_PORTS*2-1:0]          s_arburst,
  input  logic [NUM_PORTS-1:0]            s_awvalid,
  output logic [NUM_PORTS-1:0]            s_awready,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]   s_awid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_awaddr,
  input  logic [NUM_PORTS*8-1:0]          s_awlen,
  input  logic [NUM_PORTS*3-1:0]          s_awsize,
  input  logic [NUM_PORTS*2-1:0]          s_awburst,
  input  logic [NUM_PORTS-1:0]            s_wvalid,
  output logic [NUM_PORTS-1:0]            s_wready,
  input  logic [NUM_PORTS-1:0]            s_wlast,
  output logic [NUM_PORTS-1:0]            s_rvalid,
  input  logic [NUM_PORTS-1:0]            s_rready,
  output logic [NUM_PORTS*ID_WIDTH-1:0]   s_rid,
  output logic [NUM_PORTS-1:0]            s_bvalid,
  input  logic [NUM_PORTS-1:0]            s_bready,
  output logic [NUM_PORTS*ID_WIDTH-1:0]   s_bid,
  output logic                            m_arvalid,
  input  logic                            m_arready,
  output logic [MID_WIDTH-1:0]            m_arid,
  output logic [ADDR_WIDTH-1:0]           m_araddr,
  output logic [7:0]                      m_arlen,
  output logic [2:0]                      m_arsize,
  output logic [1:0]                      m_arburst,
  output logic                            m_awvalid,
  input  logic                            m_awready,
  output logic [MID_WIDTH-1:0]            m_awid,
  output logic [ADDR_WIDTH-1:0]           m_awaddr,
  output logic [7:0]                      m_awlen,
  output logic [2:0]                      m_awsize,
  output logic [1:0]                      m_awburst,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  output logic                            m_wlast,
  input  logic                            m_rvalid,
  output logic                            m_rready,
  input  logic [MID_WIDTH-1:0]            m_rid,
  input  logic                            m_bvalid,
  output logic                            m_bready,
  input  logic [MID_WIDTH-1:0]            m_bid
`ifdef EMULIB_TIMING_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  ar_grant_cnt,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  aw_grant_cnt
`endif
);

  logic [NUM_PORTS-1:0] ar_grant;
  logic [IDX_WIDTH-1:0] ar_idx;
  logic                 ar_valid;
  logic                 ar_hs;
  logic [NUM_PORTS-1:0] aw_grant;
  logic [IDX_WIDTH-1:0] aw_idx;
  logic                 aw_valid;
  logic                 aw_hs;
  logic                 aw_enable;

  w_state_e             w_state_q;
  w_state_e             w_state_d;
  logic [IDX_WIDTH-1:0] w_idx_q;
  logic [IDX_WIDTH-1:0] w_idx_d;
  logic [IDX_WIDTH-1:0] w_sel;
  logic                 w_route;
  logic                 w_hs;
  logic                 wlast_hs;

  logic [IDX_WIDTH-1:0] r_idx;
  logic [IDX_WIDTH-1:0] b_idx;

  assign ar_hs     = ar_valid & m_arready;
  assign aw_hs     = aw_valid & m_awready;
  assign aw_enable = !rst && (w_state_q == W_IDLE);

  emulib_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_ar_arb (
    .clk    (clk),
    .rst    (rst),
    .enable (!rst),
    .req    (s_arvalid),
    .advance(ar_hs),
    .grant  (ar_grant),
    .idx    (ar_idx),
    .valid  (ar_valid)
  );

  // AW is blocked while a write burst owns the W channel.
  emulib_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_aw_arb (
    .clk    (clk),
    .rst    (rst),
    .enable (aw_enable),
    .req    (s_awvalid),
    .advance(aw_hs),
    .grant  (aw_grant),
    .idx    (aw_idx),
    .valid  (aw_valid)
  );

  assign s_arready = ar_grant & {NUM_PORTS{m_arready}};
  assign s_awready = aw_grant & {NUM_PORTS{m_awready}};
  assign m_arvalid = ar_valid;
  assign m_awvalid = aw_valid;

  // Address payload muxes; the index is prepended so responses can be
  // steered back.
  always_comb begin
    m_arid    = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = '0;
    m_arburst = '0;
    m_awid    = '0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awsize  = '0;
    m_awburst = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ar_idx == IDX_WIDTH'(i)) begin
        m_arid    = {ar_idx, s_arid[i*ID_WIDTH +: ID_WIDTH]};
        m_araddr  = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_arlen   = s_arlen[i*8 +: 8];
        m_arsize  = s_arsize[i*3 +: 3];
        m_arburst = s_arburst[i*2 +: 2];
      end
      if (aw_idx == IDX_WIDTH'(i)) begin
        m_awid    = {aw_idx, s_awid[i*ID_WIDTH +: ID_WIDTH]};
        m_awaddr  = s_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_awlen   = s_awlen[i*8 +: 8];
        m_awsize  = s_awsize[i*3 +: 3];
        m_awburst = s_awburst[i*2 +: 2];
      end
    end
  end

  // In IDLE the W channel opens only in the cycle the AW handshakes, using
  // that cycle's AW grant directly; during a burst the registered owner is used.
  assign w_sel   = (w_state_q == W_BURST) ? w_idx_q : aw_idx;
  assign w_route = !rst && ((w_state_q == W_BURST) || aw_hs);

  always_comb begin
    m_wvalid = 1'b0;
    m_wlast  = 1'b0;
    s_wready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_route && (w_sel == IDX_WIDTH'(i))) begin
        m_wvalid    = s_wvalid[i];
        m_wlast     = s_wlast[i];
        s_wready[i] = m_wready;
      end
    end
  end

  assign w_hs     = m_wvalid & m_wready;
  assign wlast_hs = w_hs & m_wlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
    end
  end

  // A single-beat write whose last beat completes alongside its AW never
  // enters W_BURST.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_idx_d = aw_idx;
          if (!wlast_hs) w_state_d = W_BURST;
        end
      end
      W_BURST: begin
        if (wlast_hs) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign r_idx = m_rid[MID_WIDTH-1 -: IDX_WIDTH];
  assign b_idx = m_bid[MID_WIDTH-1 -: IDX_WIDTH];

  // Response steering. An index with no matching port (non power-of-two
  // NUM_PORTS) keeps ready high so the stray response is drained.
  always_comb begin
    s_rvalid = '0;
    s_rid    = '0;
    m_rready = 1'b1;
    s_bvalid = '0;
    s_bid    = '0;
    m_bready = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_idx == IDX_WIDTH'(i)) begin
        s_rvalid[i]                   = m_rvalid;
        s_rid[i*ID_WIDTH +: ID_WIDTH] = m_rvalid ? m_rid[ID_WIDTH-1:0] : '0;
        m_rready                      = s_rready[i];
      end
      if (b_idx == IDX_WIDTH'(i)) begin
        s_bvalid[i]                   = m_bvalid;
        s_bid[i*ID_WIDTH +: ID_WIDTH] = m_bvalid ? m_bid[ID_WIDTH-1:0] : '0;
        m_bready                      = s_bready[i];
      end
    end
  end

`ifdef EMULIB_TIMING_ARB_STATS_EN
  // Per-port grant counters, saturating at all-ones.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stats
    always_ff @(posedge clk) begin
      if (rst) begin
        ar_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] <= '0;
        aw_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] <= '0;
      end else begin
        if (ar_hs && ar_grant[g] && (ar_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] != '1))
          ar_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] <= ar_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
        if (aw_hs && aw_grant[g] && (aw_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] != '1))
          aw_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] <= aw_grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
      end
    end
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_emulib_axi_timing_arb.sv
// tb_emulib_axi_timing_arb
// Self-checking bench for emulib_axi_timing_arb with NUM_PORTS=3, so both the
// pointer wrap and the out-of-range response index are reachable. Expected
// values come from a transaction-level model of the arbitration rules.
module tb_emulib_axi_timing_arb;

  localparam int N      = 3;
  localparam int ADDR_W = 16;
  localparam int IW     = 4;
  localparam int XW     = 2;
  localparam int DIW    = IW + XW;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]        s_arvalid, s_arready, s_awvalid, s_awready;
  logic [N*IW-1:0]     s_arid, s_awid;
  logic [N*ADDR_W-1:0] s_araddr, s_awaddr;
  logic [N*8-1:0]      s_arlen, s_awlen;
  logic [N*3-1:0]      s_arsize, s_awsize;
  logic [N*2-1:0]      s_arburst, s_awburst;
  logic [N-1:0]        s_wvalid, s_wready, s_wlast;
  logic [N-1:0]        s_rvalid, s_rready, s_bvalid, s_bready;
  logic [N*IW-1:0]     s_rid, s_bid;
  logic                m_arvalid, m_arready, m_awvalid, m_awready;
  logic [DIW-1:0]      m_arid, m_awid, m_rid, m_bid;
  logic [ADDR_W-1:0]   m_araddr, m_awaddr;
  logic [7:0]          m_arlen, m_awlen;
  logic [2:0]          m_arsize, m_awsize;
  logic [1:0]          m_arburst, m_awburst;
  logic                m_wvalid, m_wready, m_wlast;
  logic                m_rvalid, m_rready, m_bvalid, m_bready;
`ifdef EMULIB_TIMING_ARB_STATS_EN
  logic [N*32-1:0]     ar_grant_cnt, aw_grant_cnt;
`endif

  // Per-port request payloads, packed into the flattened ports below.
  logic [IW-1:0]     ar_id[N], aw_id[N];
  logic [ADDR_W-1:0] ar_addr[N], aw_addr[N];
  logic [7:0]        ar_len[N], aw_len[N];
  logic [2:0]        ar_size[N], aw_size[N];
  logic [1:0]        ar_burst[N], aw_burst[N];
  logic [N-1:0]      ar_pend, aw_pend;

  // Model state: pointers, held grant (-1 none), W owner (-1 idle).
  int ar_ptr, aw_ptr, ar_hold, aw_hold, w_owner;
  int ar_cnt[N], aw_cnt[N];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_arid[i*IW +: IW]         = ar_id[i];
      s_araddr[i*ADDR_W +: ADDR_W] = ar_addr[i];
      s_arlen[i*8 +: 8]          = ar_len[i];
      s_arsize[i*3 +: 3]         = ar_size[i];
      s_arburst[i*2 +: 2]        = ar_burst[i];
      s_awid[i*IW +: IW]         = aw_id[i];
      s_awaddr[i*ADDR_W +: ADDR_W] = aw_addr[i];
      s_awlen[i*8 +: 8]          = aw_len[i];
      s_awsize[i*3 +: 3]         = aw_size[i];
      s_awburst[i*2 +: 2]        = aw_burst[i];
    end
  end

  emulib_axi_timing_arb #(.NUM_PORTS(N), .ADDR_WIDTH(ADDR_W), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid)
`ifdef EMULIB_TIMING_ARB_STATS_EN
    , .ar_grant_cnt(ar_grant_cnt), .aw_grant_cnt(aw_grant_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic bitAt(input logic [N-1:0] v, input int p);
    return |(v & (N'(1) << p));
  endfunction

  // First requesting port when scanning ptr, ptr+1, ... modulo N.
  function automatic int pickRr(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (bitAt(req, (ptr + k) % N)) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic checkResp(input string tag, input logic v, input logic [DIW-1:0] id,
                           input logic [N-1:0] rdy, input logic [N-1:0] o_valid,
                           input logic [N*IW-1:0] o_id, input logic o_ready);
    int ri;
    logic [N*IW-1:0] eid;
    ri = int'(id >> IW);
    if (ri < N) begin
      eid = {{(N*IW-IW){1'b0}}, id[IW-1:0]} << (ri * IW);
      checkOutput({tag, "_valid"}, 64'(o_valid), v ? (64'd1 << ri) : 64'd0);
      checkOutput({tag, "_id"}, 64'(o_id), v ? 64'(eid) : 64'd0);
      checkOutput({tag, "_ready"}, 64'(o_ready), 64'(bitAt(rdy, ri)));
    end else begin
      checkOutput({tag, "_valid_oor"}, 64'(o_valid), 64'd0);
      checkOutput({tag, "_ready_oor"}, 64'(o_ready), 64'd1);
    end
  endtask

  // Compares every output against the model for the inputs currently
  // applied, then commits the model state at the clock edge.
  task automatic applyStimulus;
    int e_ar, e_aw, e_w;
    logic e_ar_hs, e_aw_hs, e_w_hs, e_wlast_hs;
    #1;
    if (rst) e_ar = -1;
    else if (ar_hold >= 0) e_ar = ar_hold;
    else e_ar = pickRr(s_arvalid, ar_ptr);
    if (rst || w_owner >= 0) e_aw = -1;
    else if (aw_hold >= 0) e_aw = aw_hold;
    else e_aw = pickRr(s_awvalid, aw_ptr);
    e_ar_hs = (e_ar >= 0) && m_arready;
    e_aw_hs = (e_aw >= 0) && m_awready;
    e_w = rst ? -1 : (w_owner >= 0) ? w_owner : e_aw_hs ? e_aw : -1;

    checkOutput("m_arvalid", 64'(m_arvalid), 64'(e_ar >= 0));
    checkOutput("s_arready", 64'(s_arready), e_ar_hs ? (64'd1 << e_ar) : 64'd0);
    if (e_ar >= 0)
      checkOutput("m_ar_payload", 64'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst}),
                  64'({XW'(e_ar), ar_id[e_ar], ar_addr[e_ar], ar_len[e_ar], ar_size[e_ar], ar_burst[e_ar]}));
    checkOutput("m_awvalid", 64'(m_awvalid), 64'(e_aw >= 0));
    checkOutput("s_awready", 64'(s_awready), e_aw_hs ? (64'd1 << e_aw) : 64'd0);
    if (e_aw >= 0)
      checkOutput("m_aw_payload", 64'({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst}),
                  64'({XW'(e_aw), aw_id[e_aw], aw_addr[e_aw], aw_len[e_aw], aw_size[e_aw], aw_burst[e_aw]}));

    e_w_hs     = (e_w >= 0) && bitAt(s_wvalid, e_w) && m_wready;
    e_wlast_hs = e_w_hs && bitAt(s_wlast, e_w);
    checkOutput("m_wvalid", 64'(m_wvalid), 64'((e_w >= 0) && bitAt(s_wvalid, e_w)));
    checkOutput("s_wready", 64'(s_wready), ((e_w >= 0) && m_wready) ? (64'd1 << e_w) : 64'd0);
    if (e_w >= 0) checkOutput("m_wlast", 64'(m_wlast), 64'(bitAt(s_wlast, e_w)));

    checkResp("r", m_rvalid, m_rid, s_rready, s_rvalid, s_rid, m_rready);
    checkResp("b", m_bvalid, m_bid, s_bready, s_bvalid, s_bid, m_bready);

    @(posedge clk);
    if (rst) begin
      ar_ptr = 0; aw_ptr = 0; ar_hold = -1; aw_hold = -1; w_owner = -1;
      for (int i = 0; i < N; i++) begin ar_cnt[i] = 0; aw_cnt[i] = 0; end
    end else begin
      if (e_ar_hs) begin
        ar_ptr = (e_ar + 1) % N; ar_hold = -1; ar_cnt[e_ar]++; ar_pend[e_ar] = 1'b0;
      end else ar_hold = e_ar;
      if (e_aw_hs) begin
        aw_ptr = (e_aw + 1) % N; aw_hold = -1; aw_cnt[e_aw]++; aw_pend[e_aw] = 1'b0;
      end else if (w_owner < 0) aw_hold = e_aw;
      if (w_owner >= 0) begin
        if (e_wlast_hs) w_owner = -1;
      end else if (e_aw_hs && !e_wlast_hs) w_owner = e_aw;
    end
    @(negedge clk);
  endtask

  task automatic resetCycle;
    rst = 1'b1; s_arvalid = '0; s_awvalid = '0; s_wvalid = '0; s_wlast = '0;
    applyStimulus;
    rst = 1'b0;
  endtask

  initial begin
    ar_ptr = 0; aw_ptr = 0; ar_hold = -1; aw_hold = -1; w_owner = -1;
    ar_pend = '0; aw_pend = '0;
    for (int i = 0; i < N; i++) begin
      ar_cnt[i] = 0; aw_cnt[i] = 0;
      ar_id[i] = IW'(i + 3); ar_addr[i] = ADDR_W'(16'h100 * (i + 1)); ar_len[i] = 8'(i);
      ar_size[i] = 3'd2; ar_burst[i] = 2'd1;
      aw_id[i] = IW'(i + 8); aw_addr[i] = ADDR_W'(16'h800 + i); aw_len[i] = 8'd0;
      aw_size[i] = 3'd3; aw_burst[i] = 2'd1;
    end
    m_rvalid = 0; m_rid = '0; s_rready = '0; m_bvalid = 0; m_bid = '0; s_bready = '0;

    // Reset with every request and ready asserted: nothing state-driven moves.
    rst = 1'b1; s_arvalid = '1; s_awvalid = '1; s_wvalid = '1; s_wlast = '0;
    m_arready = 1; m_awready = 1; m_wready = 1;
    #1;
    checkOutput("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    checkOutput("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    checkOutput("rst_s_wready", 64'(s_wready), 64'd0);
    applyStimulus;

    // All ports requesting, always ready: grants rotate 0,1,2,0,1,2.
    rst = 1'b0; s_awvalid = '0; s_wvalid = '0;
    for (int k = 0; k < 6; k++) begin
      #1 checkOutput("rr_grant", 64'(m_arid[DIW-1 -: XW]), 64'(k % N));
      applyStimulus;
    end

    // Stalled grant on port 2 is held when port 0 shows up later.
    resetCycle;
    s_arvalid = 3'b100; m_arready = 0;
    applyStimulus;
    s_arvalid = 3'b101;
    for (int k = 0; k < 2; k++) begin
      #1 checkOutput("hold_idx", 64'(m_arid[DIW-1 -: XW]), 64'd2);
      checkOutput("hold_addr", 64'(m_araddr), 64'h300);
      applyStimulus;
    end
    m_arready = 1;
    applyStimulus;
    s_arvalid = 3'b001;
    #1 checkOutput("after_hold_idx", 64'(m_arid[DIW-1 -: XW]), 64'd0);
    applyStimulus;

    // Port 1 four-beat write; port 0 W never accepted, port 0 AW waits.
    resetCycle;
    s_arvalid = '0; aw_len[1] = 8'd3; s_awvalid = 3'b010;
    s_wvalid = 3'b001; s_wlast = 3'b001;
    applyStimulus;
    s_awvalid = 3'b001;
    for (int b = 0; b < 4; b++) begin
      s_wvalid = 3'b011; s_wlast = (b == 3) ? 3'b011 : 3'b001;
      #1 checkOutput("burst_s_wready", 64'(s_wready), 64'b010);
      checkOutput("burst_m_awvalid", 64'(m_awvalid), 64'd0);
      applyStimulus;
    end
    s_wvalid = '0;
    #1 checkOutput("post_burst_aw_idx", 64'({m_awvalid, m_awid[DIW-1 -: XW]}), 64'b100);
    applyStimulus;

    // Reset in the middle of port 0's burst: FSM idle, pointer back at 0.
    rst = 1'b1;
    applyStimulus;
    rst = 1'b0; s_awvalid = 3'b011;
    #1 checkOutput("rst_burst_aw_idx", 64'({m_awvalid, m_awid[DIW-1 -: XW]}), 64'b100);
    applyStimulus;

    // Single-beat write: AW and its only W beat in one cycle, FSM stays idle.
    resetCycle;
    s_awvalid = 3'b100; s_wvalid = 3'b100; s_wlast = 3'b100;
    #1 checkOutput("single_s_awready", 64'(s_awready), 64'b100);
    checkOutput("single_s_wready", 64'(s_wready), 64'b100);
    applyStimulus;
    s_awvalid = 3'b001; s_wvalid = '0; s_wlast = '0;
    #1 checkOutput("single_idle_awvalid", 64'(m_awvalid), 64'd1);
    applyStimulus;

    // Response routing, including an index with no matching port.
    m_rvalid = 1; m_rid = {2'd1, 4'hA}; s_rready = 3'b000;
    #1 checkOutput("r_route_valid", 64'(s_rvalid), 64'b010);
    checkOutput("r_route_id", 64'(s_rid[IW +: IW]), 64'hA);
    checkOutput("r_route_ready0", 64'(m_rready), 64'd0);
    s_rready = 3'b010;
    #1 checkOutput("r_route_ready1", 64'(m_rready), 64'd1);
    m_bvalid = 1; m_bid = {2'd3, 4'h5}; s_bready = '0;
    #1 checkOutput("b_oor_ready", 64'(m_bready), 64'd1);
    applyStimulus;

    // Randomized traffic with AXI-compliant masters and occasional resets.
    resetCycle;
    ar_pend = '0; aw_pend = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!ar_pend[i] && $urandom_range(2) == 0) begin
          ar_pend[i] = 1'b1; ar_id[i] = IW'($urandom); ar_addr[i] = ADDR_W'($urandom);
          ar_len[i] = 8'($urandom); ar_size[i] = 3'($urandom); ar_burst[i] = 2'($urandom);
        end
        if (!aw_pend[i] && $urandom_range(2) == 0) begin
          aw_pend[i] = 1'b1; aw_id[i] = IW'($urandom); aw_addr[i] = ADDR_W'($urandom);
          aw_len[i] = 8'($urandom); aw_size[i] = 3'($urandom); aw_burst[i] = 2'($urandom);
        end
        s_wlast[i] = ($urandom_range(3) == 0);
      end
      s_arvalid = ar_pend; s_awvalid = aw_pend;
      s_wvalid  = N'($urandom);
      m_arready = 1'($urandom); m_awready = 1'($urandom); m_wready = 1'($urandom);
      m_rvalid  = 1'($urandom); m_rid = DIW'($urandom); s_rready = N'($urandom);
      m_bvalid  = 1'($urandom); m_bid = DIW'($urandom); s_bready = N'($urandom);
      rst = ($urandom_range(99) == 0);
      applyStimulus;
    end

`ifdef EMULIB_TIMING_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      checkOutput("ar_grant_cnt", 64'(ar_grant_cnt[i*32 +: 32]), 64'(ar_cnt[i]));
      checkOutput("aw_grant_cnt", 64'(aw_grant_cnt[i*32 +: 32]), 64'(aw_cnt[i]));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
